muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the execute stage. Sits beside the ALU and takes the same forwarded operands (portA/portB).
- Executes MULT, MULTU, DIV and DIVU over 32 iterations, then writes the architectural HI/LO registers.
- HI/LO are read downstream by MFHI/MFLO through the EX/MEM latch. The hazard unit uses busy to stall dependent instructions.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Operand, control and HI/LO bus between the execute stage and muldiv_unit.
// The stage drives through master; the unit connects as slave.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] portA;
  logic [31:0] portB;
  logic        flush;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] wdat;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, portA, portB, flush, hi_wen, lo_wen, wdat,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, portA, portB, flush, hi_wen, lo_wen, wdat,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle on operand magnitudes; signs are fixed up at the end.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic         CLK,
  input  logic         RST,
  muldiv_unit_if.slave bus
);
  localparam logic [4:0] LAST = 5'(ITER - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] acc_step;
  logic [63:0] prod_signed;
  logic [31:0] quo_signed;
  logic [31:0] rem_signed;
  logic [31:0] a_raw;
  logic        in_signed;
  logic        in_sa;
  logic        in_sb;
  logic [31:0] in_a_mag;
  logic [31:0] in_b_mag;
  logic        accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);

    // Divide: acc = {remainder, dividend bits / quotient bits}, shifted left each step.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_rem   = div_shift[31:0] - b_q;

    acc_step = is_div_q ? {(div_ge ? div_rem : div_shift[31:0]), acc_q[30:0], div_ge}
                        : {mul_sum, acc_q[31:1]};

    prod_signed = (sa_q ^ sb_q) ? -acc_step : acc_step;
    quo_signed  = (sa_q ^ sb_q) ? -acc_step[31:0] : acc_step[31:0];
    rem_signed  = sa_q ? -acc_step[63:32] : acc_step[63:32];
    a_raw       = sa_q ? -a_q : a_q;

    in_signed = ~bus.op[0];
    in_sa     = in_signed & bus.portA[31];
    in_sb     = in_signed & bus.portB[31];
    in_a_mag  = in_sa ? -bus.portA : bus.portA;
    in_b_mag  = in_sb ? -bus.portB : bus.portB;
    accept    = (state_q != RUN) && bus.start && !bus.flush;

    case (state_q)
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST) begin
            state_d = FIN;
            if (is_div_q) begin
              if (b_q == 32'd0) begin
                hi_d = a_raw;
                lo_d = '1;
              end else begin
                hi_d = rem_signed;
                lo_d = quo_signed;
              end
            end else begin
              {hi_d, lo_d} = prod_signed;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = bus.op[1];
          sa_d     = in_sa;
          sb_d     = in_sb;
          a_d      = in_a_mag;
          b_d      = in_b_mag;
          acc_d    = {32'd0, (bus.op[1] ? in_a_mag : in_b_mag)};
        end else if (!bus.start) begin
          // A raised start (even one squashed by flush) masks MTHI/MTLO.
          if (bus.hi_wen) hi_d = bus.wdat;
          if (bus.lo_wen) lo_d = bus.wdat;
        end
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit #(.ITER(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Returns {HI, LO} for an operation, straight from the arithmetic definition.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        return p;
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        return p;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Starts one operation, scrambles operands while it runs, and waits (bounded) for done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output bit saw_done,
                        output logic [31:0] hi_o, output logic [31:0] lo_o);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.portA = a;
    bus.portB = b;
    @(negedge clk);
    bus.start   = 1'b0;
    busy_cycles = 0;
    saw_done    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        saw_done = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_cycles++;
      bus.portA = $urandom;
      bus.portB = $urandom;
      bus.op    = 2'($urandom);
      @(negedge clk);
    end
    hi_o = bus.hi;
    lo_o = bus.lo;
    $display("txn op=%0d a=%08h b=%08h busy_cycles=%0d done=%0d hi=%08h lo=%08h",
             op, a, b, busy_cycles, saw_done, hi_o, lo_o);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%08h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%08h exp=0", bus.lo); end
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] t_a  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000007, 32'h80000000};
    logic [31:0] t_b  [5] = '{32'h00000007, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] t_hi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000007, 32'h00000000};
    logic [31:0] t_lo [5] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    int bc; bit dn; logic [31:0] h, l;
    for (int k = 0; k < 5; k++) begin
      run_op(t_op[k], t_a[k], t_b[k], bc, dn, h, l);
      checks++; if (bc != 32) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=32", k, bc); end
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL dir%0d_done got=%b exp=1", k, dn); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_in_fin got=%b exp=0", k, bus.busy); end
      checks++; if (h !== t_hi[k]) begin failures++; $display("FAIL dir%0d_hi got=%08h exp=%08h", k, h, t_hi[k]); end
      checks++; if (l !== t_lo[k]) begin failures++; $display("FAIL dir%0d_lo got=%08h exp=%08h", k, l, t_lo[k]); end
    end
  endtask

  task automatic test_random;
    int bc; bit dn; logic [31:0] h, l, a, b; logic [1:0] op; logic [63:0] exp;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      exp = model(op, a, b);
      run_op(op, a, b, bc, dn, h, l);
      checks++; if (dn !== 1'b1 || bc != 32) begin failures++; $display("FAIL rnd%0d_timing busy_cycles=%0d done=%b exp=32/1", k, bc, dn); end
      checks++; if (h !== exp[63:32]) begin failures++; $display("FAIL rnd%0d_hi op=%0d a=%08h b=%08h got=%08h exp=%08h", k, op, a, b, h, exp[63:32]); end
      checks++; if (l !== exp[31:0]) begin failures++; $display("FAIL rnd%0d_lo op=%0d a=%08h b=%08h got=%08h exp=%08h", k, op, a, b, l, exp[31:0]); end
    end
  endtask

  task automatic test_flush_and_reset;
    bit seen; logic [31:0] lo_before;
    @(negedge clk);
    bus.hi_wen = 1'b1; bus.wdat = 32'h11111111;
    @(negedge clk);
    bus.hi_wen = 1'b0;
    checks++; if (bus.hi !== 32'h11111111) begin failures++; $display("FAIL mthi got=%08h exp=11111111", bus.hi); end
    lo_before = bus.lo;
    bus.start = 1'b1; bus.op = 2'b11; bus.portA = $urandom; bus.portB = $urandom | 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", bus.done); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1; end
    checks++; if (seen) begin failures++; $display("FAIL flush_quiet got=activity exp=none"); end
    checks++; if (bus.hi !== 32'h11111111) begin failures++; $display("FAIL flush_hi got=%08h exp=11111111", bus.hi); end
    checks++; if (bus.lo !== lo_before) begin failures++; $display("FAIL flush_lo got=%08h exp=%08h", bus.lo, lo_before); end
    $display("txn flush at run cycle 10 hi=%08h lo=%08h", bus.hi, bus.lo);

    bus.start = 1'b1; bus.op = 2'b01; bus.portA = $urandom | 32'd1; bus.portB = $urandom | 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin failures++; $display("FAIL midrun_reset_hilo got=%08h/%08h exp=0/0", bus.hi, bus.lo); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL midrun_reset_flags got busy=%b done=%b exp=0/0", bus.busy, bus.done); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1; end
    checks++; if (seen) begin failures++; $display("FAIL midrun_reset_quiet got=activity exp=none"); end
    $display("txn reset at run cycle 20 hi=%08h lo=%08h", bus.hi, bus.lo);
  endtask

  task automatic test_back_to_back;
    logic [1:0] op1, op2; logic [31:0] a1, b1, a2, b2; logic [63:0] e1, e2;
    int bc; bit dn;
    op1 = 2'($urandom); a1 = $urandom; b1 = $urandom;
    op2 = 2'($urandom); a2 = $urandom; b2 = $urandom_range(1, 1000);
    e1 = model(op1, a1, b1);
    e2 = model(op2, a2, b2);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op1; bus.portA = a1; bus.portB = b1;
    @(negedge clk);
    bus.start = 1'b0; bc = 0; dn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin dn = 1'b1; break; end
      if (bus.busy === 1'b1) bc++;
      bus.start = (i == 5);
      bus.portA = $urandom; bus.portB = $urandom; bus.op = 2'($urandom);
      @(negedge clk);
    end
    checks++; if (!dn || bc != 32) begin failures++; $display("FAIL b2b_first_timing busy_cycles=%0d done=%b exp=32/1", bc, dn); end
    checks++; if ({bus.hi, bus.lo} !== e1) begin failures++; $display("FAIL b2b_first_result got=%08h_%08h exp=%016h", bus.hi, bus.lo, e1); end
    $display("txn b2b first op=%0d a=%08h b=%08h hi=%08h lo=%08h", op1, a1, b1, bus.hi, bus.lo);
    bus.start = 1'b1; bus.op = op2; bus.portA = a2; bus.portB = b2;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL b2b_restart got busy=%b done=%b exp=1/0", bus.busy, bus.done); end
    bc = 0; dn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin dn = 1'b1; break; end
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
    end
    checks++; if (!dn || bc != 32) begin failures++; $display("FAIL b2b_second_timing busy_cycles=%0d done=%b exp=32/1", bc, dn); end
    checks++; if ({bus.hi, bus.lo} !== e2) begin failures++; $display("FAIL b2b_second_result got=%08h_%08h exp=%016h", bus.hi, bus.lo, e2); end
    $display("txn b2b second op=%0d a=%08h b=%08h hi=%08h lo=%08h", op2, a2, b2, bus.hi, bus.lo);
  endtask

  task automatic test_write_priority;
    int bc; bit dn; logic [31:0] w, h_before;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.portA = 32'd2; bus.portB = 32'd3;
    bus.hi_wen = 1'b1; bus.lo_wen = 1'b1; bus.wdat = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_wen = 1'b0; bus.wdat = 32'hCAFEF00D;
    bc = 0; dn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin dn = 1'b1; break; end
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
    end
    bus.lo_wen = 1'b0;
    checks++; if (!dn || bc != 32) begin failures++; $display("FAIL startwins_timing busy_cycles=%0d done=%b exp=32/1", bc, dn); end
    checks++; if (bus.lo !== 32'd6 || bus.hi !== 32'd0) begin failures++; $display("FAIL startwins_result got=%08h/%08h exp=0/6", bus.hi, bus.lo); end
    $display("txn start+wen op=1 a=2 b=3 hi=%08h lo=%08h", bus.hi, bus.lo);
    w = $urandom;
    @(negedge clk);
    bus.hi_wen = 1'b1; bus.lo_wen = 1'b1; bus.wdat = w;
    @(negedge clk);
    bus.hi_wen = 1'b0; bus.lo_wen = 1'b0;
    checks++; if (bus.hi !== w || bus.lo !== w) begin failures++; $display("FAIL dual_write got=%08h/%08h exp=%08h", bus.hi, bus.lo, w); end
    $display("txn mthi+mtlo wdat=%08h hi=%08h lo=%08h", w, bus.hi, bus.lo);
    h_before = bus.hi;
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.portA = 32'd5; bus.portB = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_blocks_start got busy=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== h_before) begin failures++; $display("FAIL flush_blocks_start_hi got=%08h exp=%08h", bus.hi, h_before); end
    $display("txn start+flush in idle busy=%b hi=%08h", bus.busy, bus.hi);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.portA = '0; bus.portB = '0;
    bus.flush = 1'b0; bus.hi_wen = 1'b0; bus.lo_wen = 1'b0; bus.wdat = '0;
    test_reset();
    test_directed();
    test_random();
    test_flush_and_reset();
    test_back_to_back();
    test_write_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
